// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO and emulates fixed mult/div latency with a countdown.
// Optional MADD/MADDU accumulate ops (E_MDOp 9/10) are enabled by defining MDU_MADD_EN.
//
// state | meaning
// IDLE  | no operation in flight; md ops and MTHI/MTLO may be accepted
// RUN   | result held in pending, counter counting down to commit
module e_mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        E_MDStart,
  output logic        E_MDBusy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic               is_md, is_mult;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        a_mag, b_mag, b_sdiv, q_mag, r_mag, q_s, r_s;
  logic [31:0]        b_udiv, q_u, r_u;
  logic [31:0]        res_hi, res_lo;

  // Datapath: products and quotients for whichever op is presented.
  // Signed division works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'd0, A} * {32'd0, B};
    a_mag  = A[31] ? (~A + 32'd1) : A;
    b_mag  = B[31] ? (~B + 32'd1) : B;
    b_sdiv = (B == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_sdiv;
    r_mag  = a_mag % b_sdiv;
    q_s    = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = A[31] ? (~r_mag + 32'd1) : r_mag;
    b_udiv = (B == 32'd0) ? 32'd1 : B;
    q_u    = A / b_udiv;
    r_u    = A % b_udiv;
  end

  always_comb begin
    res_hi  = hi_q;
    res_lo  = lo_q;
    is_md   = 1'b0;
    is_mult = 1'b0;
    case (E_MDOp)
      OP_MULT:  begin is_md = 1'b1; is_mult = 1'b1; {res_hi, res_lo} = prod_s; end
      OP_MULTU: begin is_md = 1'b1; is_mult = 1'b1; {res_hi, res_lo} = prod_u; end
      OP_DIV: begin
        is_md = 1'b1;
        if (B != 32'd0) begin
          res_lo = q_s;
          res_hi = r_s;
        end
      end
      OP_DIVU: begin
        is_md = 1'b1;
        if (B != 32'd0) begin
          res_lo = q_u;
          res_hi = r_u;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_md = 1'b1; is_mult = 1'b1; {res_hi, res_lo} = {hi_q, lo_q} + prod_s; end
      OP_MADDU: begin is_md = 1'b1; is_mult = 1'b1; {res_hi, res_lo} = {hi_q, lo_q} + prod_u; end
`endif
      default: ;
    endcase
  end

  assign E_MDStart = is_md & ~busy_q & ~Req;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      IDLE: begin
        if (E_MDStart) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          cnt_d     = is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          state_d   = RUN;
          busy_d    = 1'b1;
        end else if (!busy_q && !Req) begin
          if (E_MDOp == OP_MTHI) hi_d = A;
          if (E_MDOp == OP_MTLO) lo_d = A;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign E_MDBusy = busy_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign E_MDOut  = (E_MDOp == OP_MFHI) ? hi_q :
                    (E_MDOp == OP_MFLO) ? lo_q : 32'd0;

endmodule
